audio_fir_sequencer: RTL and testbench

Controller for the audio CODEC sample path. It runs the read/write handshakes with audio_codec and advances an 8-tap moving-average history once per real sample, not once per clock. Taps are accumulated sequentially with one accumulator per channel. It sits between audio_codec and the top level, replacing free-running per-clock shift registers with sample-gated sequencing.

---
 rtl/audio_fir_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_audio_fir_sequencer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_fir_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : audio_fir_sequencer
//  Description : Sample-gated sequencer for the audio CODEC path. Handshakes
//                one input pair from the CODEC and pushes it into a TAPS-deep
//                per-channel history. It then sums that history one tap per
//                cycle and writes the moving average back to the CODEC.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_fir_sequencer #(
  parameter int DATA_W    = 24,
  parameter int TAPS      = 8,
  parameter int LOG2_TAPS = 3
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              enable,
  input  logic              read_ready,
  input  logic [DATA_W-1:0] readdata_left,
  input  logic [DATA_W-1:0] readdata_right,
  output logic              read,
  input  logic              write_ready,
  output logic              write,
  output logic [DATA_W-1:0] writedata_left,
  output logic [DATA_W-1:0] writedata_right,
  output logic              busy,
  output logic [15:0]       sample_count
);

  localparam int ACC_W = DATA_W + LOG2_TAPS;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_ACCUM   = 3'd2;
  localparam logic [2:0] S_DONE    = 3'd3;
  localparam logic [2:0] S_WAIT_WR = 3'd4;
  localparam logic [2:0] S_WRITE   = 3'd5;

  localparam logic [LOG2_TAPS-1:0] PTR_ONE  = LOG2_TAPS'(1);
  localparam logic [LOG2_TAPS-1:0] IDX_LAST = LOG2_TAPS'(TAPS - 1);

  logic [2:0]              state_q, state_d;
  logic [DATA_W-1:0]       cap_l_q, cap_l_d;
  logic [DATA_W-1:0]       cap_r_q, cap_r_d;
  logic [DATA_W-1:0]       hist_l_q [TAPS];
  logic [DATA_W-1:0]       hist_l_d [TAPS];
  logic [DATA_W-1:0]       hist_r_q [TAPS];
  logic [DATA_W-1:0]       hist_r_d [TAPS];
  logic signed [ACC_W-1:0] acc_l_q, acc_l_d;
  logic signed [ACC_W-1:0] acc_r_q, acc_r_d;
  logic [LOG2_TAPS-1:0]    idx_q, idx_d;
  logic [LOG2_TAPS-1:0]    wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0]       wd_l_q, wd_l_d;
  logic [DATA_W-1:0]       wd_r_q, wd_r_d;
  logic                    read_q, read_d;
  logic                    write_q, write_d;
  logic [15:0]             count_q, count_d;
  logic signed [ACC_W-1:0] ext_l, ext_r;

  // Sign-extend the tap currently addressed by idx so it adds into the accumulator.
  always_comb begin
    ext_l = {{LOG2_TAPS{hist_l_q[idx_q][DATA_W-1]}}, hist_l_q[idx_q]};
    ext_r = {{LOG2_TAPS{hist_r_q[idx_q][DATA_W-1]}}, hist_r_q[idx_q]};
  end

  // Next-state and datapath control for one sample transaction.
  always_comb begin
    state_d  = state_q;
    cap_l_d  = cap_l_q;
    cap_r_d  = cap_r_q;
    hist_l_d = hist_l_q;
    hist_r_d = hist_r_q;
    acc_l_d  = acc_l_q;
    acc_r_d  = acc_r_q;
    idx_d    = idx_q;
    wr_ptr_d = wr_ptr_q;
    wd_l_d   = wd_l_q;
    wd_r_d   = wd_r_q;
    count_d  = count_q;
    read_d   = 1'b0;
    write_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable && read_ready) begin
          cap_l_d = readdata_left;
          cap_r_d = readdata_right;
          read_d  = 1'b1;
          state_d = S_CAPTURE;
        end
      end

      S_CAPTURE: begin
        hist_l_d[wr_ptr_q] = cap_l_q;
        hist_r_d[wr_ptr_q] = cap_r_q;
        acc_l_d            = '0;
        acc_r_d            = '0;
        idx_d              = '0;
        state_d            = S_ACCUM;
      end

      S_ACCUM: begin
        acc_l_d = acc_l_q + ext_l;
        acc_r_d = acc_r_q + ext_r;
        idx_d   = idx_q + PTR_ONE;
        if (idx_q == IDX_LAST) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        // Dropping the low LOG2_TAPS bits is the arithmetic shift (floor divide),
        // and the remaining DATA_W bits are exactly the truncated result.
        wd_l_d = acc_l_q[ACC_W-1:LOG2_TAPS];
        wd_r_d = acc_r_q[ACC_W-1:LOG2_TAPS];
        // A ready CODEC takes the result without a dead cycle in WAIT_WR.
        if (write_ready) begin
          write_d = 1'b1;
          state_d = S_WRITE;
        end else begin
          state_d = S_WAIT_WR;
        end
      end

      S_WAIT_WR: begin
        if (write_ready) begin
          write_d = 1'b1;
          state_d = S_WRITE;
        end
      end

      S_WRITE: begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (count_q != 16'hFFFF) begin
          count_d = count_q + 16'd1;
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, history and output registers; reset clears everything at once.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cap_l_q  <= '0;
      cap_r_q  <= '0;
      hist_l_q <= '{default: '0};
      hist_r_q <= '{default: '0};
      acc_l_q  <= '0;
      acc_r_q  <= '0;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      wd_l_q   <= '0;
      wd_r_q   <= '0;
      read_q   <= 1'b0;
      write_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cap_l_q  <= cap_l_d;
      cap_r_q  <= cap_r_d;
      hist_l_q <= hist_l_d;
      hist_r_q <= hist_r_d;
      acc_l_q  <= acc_l_d;
      acc_r_q  <= acc_r_d;
      idx_q    <= idx_d;
      wr_ptr_q <= wr_ptr_d;
      wd_l_q   <= wd_l_d;
      wd_r_q   <= wd_r_d;
      read_q   <= read_d;
      write_q  <= write_d;
      count_q  <= count_d;
    end
  end

  // Pulses are registered on entry to CAPTURE / WRITE, so they span exactly that state.
  assign read            = read_q;
  assign write           = write_q;
  assign writedata_left  = wd_l_q;
  assign writedata_right = wd_r_q;
  assign busy            = (state_q != S_IDLE);
  assign sample_count    = count_q;

endmodule
`default_nettype wire

// File: tb/tb_audio_fir_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_fir_sequencer
//  Description : Directed self-checking bench for audio_fir_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_fir_sequencer;

  localparam int DATA_W    = 24;
  localparam int TAPS      = 8;
  localparam int LOG2_TAPS = 3;

  logic              CLOCK_50 = 1'b0;
  logic              reset = 1'b0;
  logic              enable = 1'b0;
  logic              read_ready = 1'b0;
  logic              write_ready = 1'b0;
  logic [DATA_W-1:0] readdata_left = '0;
  logic [DATA_W-1:0] readdata_right = '0;
  logic              read;
  logic              write;
  logic [DATA_W-1:0] writedata_left;
  logic [DATA_W-1:0] writedata_right;
  logic              busy;
  logic [15:0]       sample_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  audio_fir_sequencer #(
    .DATA_W(DATA_W), .TAPS(TAPS), .LOG2_TAPS(LOG2_TAPS)
  ) dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable),
    .read_ready(read_ready), .readdata_left(readdata_left),
    .readdata_right(readdata_right), .read(read),
    .write_ready(write_ready), .write(write),
    .writedata_left(writedata_left), .writedata_right(writedata_right),
    .busy(busy), .sample_count(sample_count)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // read and write must never coincide
  always @(negedge CLOCK_50) begin
    if (!reset) begin
      checks++;
      if (read === 1'b1 && write === 1'b1) begin
        errors++;
        $display("FAIL rd_wr_overlap: read=%b write=%b required not both 1 at cycle %0d", read, write, cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic pulse_reset;
    @(negedge CLOCK_50);
    reset = 1'b1;
    read_ready = 1'b0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset = 1'b0;
    @(negedge CLOCK_50);
  endtask

  // Drive one sample pair from IDLE and return what the DUT wrote back.
  task automatic do_sample(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                           output logic [DATA_W-1:0] ol, output logic [DATA_W-1:0] orr,
                           output int rd_wait, output int lat, output bit tmo);
    int n;
    int t_read;
    tmo = 1'b0;
    readdata_left = l;
    readdata_right = r;
    read_ready = 1'b1;
    n = 0;
    while (read !== 1'b1 && n < 40) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (read !== 1'b1) tmo = 1'b1;
    rd_wait = n;
    t_read = cyc;
    read_ready = 1'b0;
    n = 0;
    while (write !== 1'b1 && n < 200) begin
      @(negedge CLOCK_50);
      n++;
    end
    if (write !== 1'b1) tmo = 1'b1;
    lat = cyc - t_read;
    ol = writedata_left;
    orr = writedata_right;
    @(negedge CLOCK_50);
  endtask

  task automatic test_reset;
    logic [DATA_W-1:0] ol, orr;
    int rw, lat, n;
    bit tmo;
    pulse_reset();
    enable = 1'b1;
    write_ready = 1'b1;
    checks++;
    if ({read, write, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: read/write/busy=%b required 000", {read, write, busy});
    end
    checks++;
    if (writedata_left !== 24'h0 || writedata_right !== 24'h0 || sample_count !== 16'h0) begin
      errors++; $display("FAIL reset_data: wl=%h wr=%h cnt=%h required 0/0/0", writedata_left, writedata_right, sample_count);
    end
    do_sample(24'h000400, 24'h000400, ol, orr, rw, lat, tmo);
    checks++;
    if (tmo || ol !== 24'h000080 || orr !== 24'h000080) begin
      errors++; $display("FAIL reset_pre: l=%h r=%h tmo=%0d required 000080/000080", ol, orr, tmo);
    end
    // start a new transaction and kill it in ACCUM
    readdata_left = 24'h000400;
    readdata_right = 24'h000400;
    read_ready = 1'b1;
    n = 0;
    while (read !== 1'b1 && n < 40) begin @(negedge CLOCK_50); n++; end
    read_ready = 1'b0;
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL reset_mid_busy: busy=%b required 1 before reset", busy);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({read, write, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_async_ctrl: read/write/busy=%b required 000", {read, write, busy});
    end
    checks++;
    if (writedata_left !== 24'h0 || writedata_right !== 24'h0 || sample_count !== 16'h0) begin
      errors++; $display("FAIL reset_async_data: wl=%h wr=%h cnt=%h required 0/0/0", writedata_left, writedata_right, sample_count);
    end
    @(negedge CLOCK_50);
    reset = 1'b0;
    n = 0;
    repeat (5) begin
      @(negedge CLOCK_50);
      if (read !== 1'b0 || write !== 1'b0 || busy !== 1'b0) n++;
    end
    checks++;
    if (n != 0) begin
      errors++; $display("FAIL reset_quiet: %0d cycles with activity required 0", n);
    end
    do_sample(24'h000080, 24'h000100, ol, orr, rw, lat, tmo);
    checks++;
    if (tmo || ol !== 24'h000010 || orr !== 24'h000020) begin
      errors++; $display("FAIL reset_zero_hist: l=%h r=%h tmo=%0d required 000010/000020", ol, orr, tmo);
    end
  endtask

  task automatic test_impulse;
    logic [DATA_W-1:0] ol, orr, l, exp_l;
    int rw, lat;
    bit tmo;
    pulse_reset();
    enable = 1'b1;
    write_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      l = (k == 0) ? 24'h000800 : 24'h000000;
      exp_l = (k < 8) ? 24'h000100 : 24'h000000;
      do_sample(l, 24'h0, ol, orr, rw, lat, tmo);
      checks++;
      if (tmo) begin errors++; $display("FAIL impulse_timeout: sample %0d tmo=1 required 0", k); end
      checks++;
      if (ol !== exp_l) begin errors++; $display("FAIL impulse_left[%0d]: got %h required %h", k, ol, exp_l); end
      checks++;
      if (orr !== 24'h0) begin errors++; $display("FAIL impulse_right[%0d]: got %h required 000000", k, orr); end
      checks++;
      if (lat != TAPS + 2) begin errors++; $display("FAIL impulse_latency[%0d]: got %0d required %0d", k, lat, TAPS + 2); end
      checks++;
      if (rw != 1) begin errors++; $display("FAIL impulse_read_delay[%0d]: got %0d required 1", k, rw); end
    end
    checks++;
    if (sample_count !== 16'd9) begin
      errors++; $display("FAIL impulse_count: got %0d required 9", sample_count);
    end
  endtask

  task automatic test_negative;
    logic [DATA_W-1:0] ol, orr, exp_l, exp_r;
    int rw, lat, m;
    bit tmo;
    pulse_reset();
    enable = 1'b1;
    write_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      m = (k < 8) ? k : 8;
      exp_l = 24'(-m);
      exp_r = 24'(2 * m);
      do_sample(24'hFFFFF8, 24'h000010, ol, orr, rw, lat, tmo);
      checks++;
      if (tmo || ol !== exp_l) begin errors++; $display("FAIL negative_left[%0d]: got %h required %h", k, ol, exp_l); end
      checks++;
      if (orr !== exp_r) begin errors++; $display("FAIL negative_right[%0d]: got %h required %h", k, orr, exp_r); end
    end
  endtask

  task automatic test_full_scale;
    logic [DATA_W-1:0] ol, orr;
    int rw, lat;
    bit tmo;
    pulse_reset();
    enable = 1'b1;
    write_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      do_sample(24'h0, 24'h7FFFFF, ol, orr, rw, lat, tmo);
      if (k == 0) begin
        checks++;
        if (tmo || orr !== 24'h0FFFFF) begin errors++; $display("FAIL fullscale_first: got %h required 0FFFFF", orr); end
      end
    end
    checks++;
    if (tmo || orr !== 24'h7FFFFF) begin errors++; $display("FAIL fullscale_pos: got %h required 7FFFFF", orr); end
    for (int k = 0; k < 8; k++) begin
      do_sample(24'h0, 24'h800000, ol, orr, rw, lat, tmo);
    end
    checks++;
    if (tmo || orr !== 24'h800000) begin errors++; $display("FAIL fullscale_neg: got %h required 800000", orr); end
    checks++;
    if (ol !== 24'h0) begin errors++; $display("FAIL fullscale_left: got %h required 000000", ol); end
  endtask

  task automatic test_backpressure;
    logic [DATA_W-1:0] snap_l, snap_r;
    int n, bad;
    pulse_reset();
    enable = 1'b1;
    write_ready = 1'b0;
    readdata_left = 24'h000040;
    readdata_right = 24'h000080;
    read_ready = 1'b1;
    n = 0;
    while (read !== 1'b1 && n < 40) begin @(negedge CLOCK_50); n++; end
    repeat (12) @(negedge CLOCK_50);
    snap_l = writedata_left;
    snap_r = writedata_right;
    checks++;
    if (snap_l !== 24'h000008 || snap_r !== 24'h000010) begin
      errors++; $display("FAIL bp_value: l=%h r=%h required 000008/000010", snap_l, snap_r);
    end
    bad = 0;
    repeat (50) begin
      @(negedge CLOCK_50);
      if (busy !== 1'b1 || read !== 1'b0 || write !== 1'b0 ||
          writedata_left !== snap_l || writedata_right !== snap_r) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d bad cycles required 0", bad); end
    write_ready = 1'b1;
    @(negedge CLOCK_50);
    checks++;
    if (write !== 1'b1) begin errors++; $display("FAIL bp_write: write=%b required 1", write); end
    @(negedge CLOCK_50);
    checks++;
    if (write !== 1'b0 || read !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_idle: write=%b read=%b busy=%b required 0/0/0", write, read, busy);
    end
    @(negedge CLOCK_50);
    checks++;
    if (read !== 1'b1) begin errors++; $display("FAIL bp_next_read: read=%b required 1", read); end
    read_ready = 1'b0;
    n = 0;
    while (write !== 1'b1 && n < 200) begin @(negedge CLOCK_50); n++; end
    checks++;
    if (write !== 1'b1 || writedata_left !== 24'h000010 || writedata_right !== 24'h000020) begin
      errors++; $display("FAIL bp_second: write=%b l=%h r=%h required 1/000010/000020", write, writedata_left, writedata_right);
    end
    @(negedge CLOCK_50);
    checks++;
    if (sample_count !== 16'd2) begin errors++; $display("FAIL bp_count: got %0d required 2", sample_count); end
  endtask

  task automatic test_enable;
    logic [DATA_W-1:0] ol, orr;
    int rw, lat, n, bad;
    bit tmo;
    pulse_reset();
    enable = 1'b1;
    write_ready = 1'b1;
    readdata_left = 24'h000100;
    readdata_right = 24'h000200;
    read_ready = 1'b1;
    n = 0;
    while (read !== 1'b1 && n < 40) begin @(negedge CLOCK_50); n++; end
    @(negedge CLOCK_50);
    enable = 1'b0;
    n = 0;
    while (write !== 1'b1 && n < 100) begin @(negedge CLOCK_50); n++; end
    checks++;
    if (write !== 1'b1 || writedata_left !== 24'h000020 || writedata_right !== 24'h000040) begin
      errors++; $display("FAIL en_write: write=%b l=%h r=%h required 1/000020/000040", write, writedata_left, writedata_right);
    end
    @(negedge CLOCK_50);
    checks++;
    if (sample_count !== 16'd1) begin errors++; $display("FAIL en_count1: got %0d required 1", sample_count); end
    bad = 0;
    repeat (30) begin
      @(negedge CLOCK_50);
      if (read !== 1'b0 || busy !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL en_disabled: %0d active cycles required 0", bad); end
    enable = 1'b1;
    do_sample(24'h000100, 24'h000200, ol, orr, rw, lat, tmo);
    checks++;
    if (tmo || ol !== 24'h000040 || orr !== 24'h000080) begin
      errors++; $display("FAIL en_resume: l=%h r=%h tmo=%0d required 000040/000080", ol, orr, tmo);
    end
    checks++;
    if (sample_count !== 16'd2) begin errors++; $display("FAIL en_count2: got %0d required 2", sample_count); end
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_negative();
    test_full_scale();
    test_backpressure();
    test_enable();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
